// File: rtl/dem_uart_pkg.sv
// Shared 16550 definitions: register offsets, LSR/IIR constants, RX trigger encodings.
package dem_uart_pkg;

    // Register offsets on the 3-bit CPU bus
    localparam logic [2:0] AddrRbrDll = 3'd0;
    localparam logic [2:0] AddrIerDlm = 3'd1;
    localparam logic [2:0] AddrIirFcr = 3'd2;
    localparam logic [2:0] AddrLcr    = 3'd3;
    localparam logic [2:0] AddrLsr    = 3'd5;
    localparam logic [2:0] AddrScr    = 3'd7;

    // Register bit positions
    localparam int unsigned LcrDlabBit  = 7;
    localparam int unsigned FcrFlushBit = 1;
    localparam int unsigned IerErbfiBit = 0;

    // LSR fields; the transmitter is always idle from this block's point of view
    localparam logic [7:0] LsrDr   = 8'h01;
    localparam logic [7:0] LsrThre = 8'h20;
    localparam logic [7:0] LsrTemt = 8'h40;

    // IIR values with FIFOs enabled
    localparam logic [7:0] IirNoInt   = 8'hC1;
    localparam logic [7:0] IirRxAvail = 8'hC4;

    // FCR[7:6] receive trigger encodings
    typedef enum logic [1:0] {
        Trig1  = 2'b00,
        Trig4  = 2'b01,
        Trig8  = 2'b10,
        Trig14 = 2'b11
    } rx_trig_e;

    // Trigger level in characters, clamped so a small FIFO can still reach it
    function automatic int unsigned trig_chars(rx_trig_e trig, int unsigned depth);
        int unsigned lvl;
        case (trig)
            Trig1:   lvl = 1;
            Trig4:   lvl = 4;
            Trig8:   lvl = 8;
            default: lvl = 14;
        endcase
        return (lvl > depth) ? depth : lvl;
    endfunction

endpackage

// File: rtl/osd_dem_uart_rxfifo.sv
// Receive character FIFO with push, pop, flush, occupancy count and head data.
module osd_dem_uart_rxfifo #(
    parameter int unsigned Depth = 16,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [7:0]      wdata_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic [7:0]      head_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers/count; flush wins over any push or pop in the same cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Character storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/osd_dem_uart_16550_rx.sv
// Receive half of a 16550-compatible UART fed by the debug host: register decode and IRQ.
module osd_dem_uart_16550_rx
    import dem_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_req,
    input  logic [2:0] bus_addr,
    input  logic       bus_write,
    input  logic [7:0] bus_wdata,
    output logic       bus_ack,
    output logic [7:0] bus_rdata,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    output logic       irq
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic       ier_q, ier_d;
    logic [7:0] lcr_q, lcr_d;
    logic [7:0] dll_q, dll_d;
    logic [7:0] dlm_q, dlm_d;
    logic [7:0] scr_q, scr_d;
    rx_trig_e   trig_q, trig_d;

    logic            dlab;
    logic            bus_rd, bus_wr;
    logic            fifo_pop, fifo_flush;
    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_head;
    logic [CntW-1:0] fifo_count;
    logic [CntW-1:0] trig_lvl;
    logic            rx_int;

    assign dlab     = lcr_q[LcrDlabBit];
    assign bus_rd   = bus_req & ~bus_write;
    assign bus_wr   = bus_req & bus_write;
    assign bus_ack  = 1'b1;
    assign in_ready = ~fifo_full;

    // RBR reads pop; the FIFO itself ignores a pop while empty
    assign fifo_pop = bus_rd & (bus_addr == AddrRbrDll) & ~dlab;

    assign trig_lvl = CntW'(trig_chars(trig_q, FIFO_DEPTH));
    assign rx_int   = ier_q & (fifo_count >= trig_lvl);
    assign irq      = rx_int;

    osd_dem_uart_rxfifo #(
        .Depth (FIFO_DEPTH)
    ) u_rxfifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (in_valid),
        .wdata_i (in_char),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Register write decode; transmit-holding writes and unlisted offsets fall through
    always_comb begin
        ier_d      = ier_q;
        lcr_d      = lcr_q;
        dll_d      = dll_q;
        dlm_d      = dlm_q;
        scr_d      = scr_q;
        trig_d     = trig_q;
        fifo_flush = 1'b0;
        if (bus_wr) begin
            case (bus_addr)
                AddrRbrDll: begin
                    if (dlab) dll_d = bus_wdata;
                end
                AddrIerDlm: begin
                    if (dlab) dlm_d = bus_wdata;
                    else      ier_d = bus_wdata[IerErbfiBit];
                end
                AddrIirFcr: begin
                    trig_d     = rx_trig_e'(bus_wdata[7:6]);
                    fifo_flush = bus_wdata[FcrFlushBit];
                end
                AddrLcr: lcr_d = bus_wdata;
                AddrScr: scr_d = bus_wdata;
                default: ;
            endcase
        end
    end

    // Register state
    always_ff @(posedge clk) begin
        if (rst) begin
            ier_q  <= 1'b0;
            lcr_q  <= 8'h00;
            dll_q  <= 8'h00;
            dlm_q  <= 8'h00;
            scr_q  <= 8'h00;
            trig_q <= Trig1;
        end else begin
            ier_q  <= ier_d;
            lcr_q  <= lcr_d;
            dll_q  <= dll_d;
            dlm_q  <= dlm_d;
            scr_q  <= scr_d;
            trig_q <= trig_d;
        end
    end

    // Read data mux, combinational from the offset and current state
    always_comb begin
        bus_rdata = 8'h00;
        case (bus_addr)
            AddrRbrDll: begin
                if (dlab)             bus_rdata = dll_q;
                else if (!fifo_empty) bus_rdata = fifo_head;
            end
            AddrIerDlm: bus_rdata = dlab ? dlm_q : {7'b0, ier_q};
            AddrIirFcr: bus_rdata = rx_int ? IirRxAvail : IirNoInt;
            AddrLcr:    bus_rdata = lcr_q;
            AddrLsr:    bus_rdata = LsrTemt | LsrThre | (fifo_empty ? 8'h00 : LsrDr);
            AddrScr:    bus_rdata = scr_q;
            default:    bus_rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_osd_dem_uart_16550_rx.sv
// Self-checking bench: directed vector table, multi-cycle sequences, randomized model check.
module tb_osd_dem_uart_16550_rx;

    localparam int unsigned Depth = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_req, bus_write, bus_ack;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;
    logic       in_valid, in_ready, irq;
    logic [7:0] in_char;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    osd_dem_uart_16550_rx #(
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_write (bus_write),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .in_ready  (in_ready),
        .irq       (irq)
    );

    typedef enum int {OpPush, OpWr, OpRd, OpIrq, OpRdy, OpPushFlush, OpPushRd} op_e;
    typedef struct {
        op_e        op;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] got;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, want %02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus_req = 1'b1; bus_write = 1'b1; bus_addr = a; bus_wdata = d;
        step();
        bus_req = 1'b0; bus_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        bus_req = 1'b1; bus_write = 1'b0; bus_addr = a;
        @(negedge clk);
        d = bus_rdata;
        step();
        bus_req = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic push(input logic [7:0] c);
        in_valid = 1'b1; in_char = c;
        step();
        in_valid = 1'b0;
    endtask

    function automatic void add(op_e op, logic [2:0] a, logic [7:0] d, logic [7:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ier;
    logic [7:0] m_lcr, m_dll, m_dlm, m_scr;
    int         m_trig;
    int         trig_tab[4] = '{1, 4, 8, 14};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; bus_req = 1'b0; bus_write = 1'b0; bus_addr = '0; bus_wdata = '0;
        in_valid = 1'b0; in_char = '0;
        step();
        // Still in reset: status must already be clean
        bus_req = 1'b1; bus_addr = 3'd5;
        @(negedge clk);
        check("rst_lsr", bus_rdata, 8'h60);
        check("rst_rdy", {7'b0, in_ready}, 8'h01);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_ack", {7'b0, bus_ack}, 8'h01);
        step();
        bus_req = 1'b0;
        rst = 1'b0;
        rd_chk("rst_iir", 3'd2, 8'hC1);

        // Basic push/read
        add(OpPush, 0, 8'h41, 0); add(OpPush, 0, 8'h42, 0); add(OpPush, 0, 8'h43, 0);
        add(OpRd, 5, 0, 8'h61);
        add(OpRd, 0, 0, 8'h41); add(OpRd, 0, 0, 8'h42); add(OpRd, 0, 0, 8'h43);
        add(OpRd, 5, 0, 8'h60);
        add(OpRd, 0, 0, 8'h00);
        // Trigger level 4 interrupt
        add(OpWr, 1, 8'h01, 0); add(OpWr, 2, 8'h40, 0);
        add(OpPush, 0, 8'hA1, 0); add(OpPush, 0, 8'hA2, 0); add(OpPush, 0, 8'hA3, 0);
        add(OpIrq, 0, 0, 8'h00); add(OpRd, 2, 0, 8'hC1);
        add(OpPush, 0, 8'hA4, 0);
        add(OpIrq, 0, 0, 8'h01); add(OpRd, 2, 0, 8'hC4);
        add(OpRd, 0, 0, 8'hA1);
        add(OpIrq, 0, 0, 8'h00); add(OpRd, 2, 0, 8'hC1);
        add(OpWr, 2, 8'h02, 0); add(OpWr, 1, 8'h00, 0);
        add(OpRd, 5, 0, 8'h60);
        // IER upper bits read as zero
        add(OpWr, 1, 8'hFF, 0); add(OpRd, 1, 0, 8'h01); add(OpWr, 1, 8'h00, 0);
        // Divisor latch access leaves FIFO and IER alone
        add(OpPush, 0, 8'h55, 0); add(OpWr, 1, 8'h01, 0);
        add(OpWr, 3, 8'h80, 0); add(OpRd, 3, 0, 8'h80);
        add(OpWr, 0, 8'h1B, 0); add(OpWr, 1, 8'h00, 0);
        add(OpRd, 0, 0, 8'h1B); add(OpRd, 1, 0, 8'h00);
        add(OpRd, 5, 0, 8'h61);
        add(OpWr, 3, 8'h03, 0); add(OpRd, 3, 0, 8'h03);
        add(OpRd, 1, 0, 8'h01);
        add(OpRd, 0, 0, 8'h55); add(OpRd, 5, 0, 8'h60);
        add(OpWr, 1, 8'h00, 0);
        // Flush overrides a simultaneous push
        add(OpPush, 0, 8'h01, 0); add(OpPush, 0, 8'h02, 0); add(OpPush, 0, 8'h03, 0);
        add(OpPush, 0, 8'h04, 0); add(OpPush, 0, 8'h05, 0);
        add(OpPushFlush, 0, 8'h06, 0);
        add(OpRd, 5, 0, 8'h60); add(OpRd, 0, 0, 8'h00); add(OpRdy, 0, 0, 8'h01);
        // Push into empty with same-cycle read
        add(OpPushRd, 0, 8'h9A, 8'h00); add(OpRd, 0, 0, 8'h9A); add(OpRd, 5, 0, 8'h60);
        // Scratch, unlisted offsets, ignored transmit write
        add(OpWr, 7, 8'hA5, 0); add(OpRd, 7, 0, 8'hA5);
        add(OpWr, 4, 8'hFF, 0); add(OpRd, 4, 0, 8'h00); add(OpRd, 6, 0, 8'h00);
        add(OpWr, 0, 8'h77, 0); add(OpRd, 5, 0, 8'h60); add(OpRd, 0, 0, 8'h00);

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            case (vecs[i].op)
                OpPush: push(vecs[i].data);
                OpWr:   wr(vecs[i].addr, vecs[i].data);
                OpRd: begin
                    rd(vecs[i].addr, got);
                    check(nm, got, vecs[i].exp);
                end
                OpIrq: begin
                    @(negedge clk);
                    check(nm, {7'b0, irq}, vecs[i].exp);
                    step();
                end
                OpRdy: begin
                    @(negedge clk);
                    check(nm, {7'b0, in_ready}, vecs[i].exp);
                    step();
                end
                OpPushFlush: begin
                    in_valid = 1'b1; in_char = vecs[i].data;
                    bus_req = 1'b1; bus_write = 1'b1; bus_addr = 3'd2; bus_wdata = 8'h02;
                    step();
                    in_valid = 1'b0; bus_req = 1'b0; bus_write = 1'b0;
                end
                default: begin
                    in_valid = 1'b1; in_char = vecs[i].data;
                    bus_req = 1'b1; bus_write = 1'b0; bus_addr = 3'd0;
                    @(negedge clk);
                    check(nm, bus_rdata, vecs[i].exp);
                    step();
                    in_valid = 1'b0; bus_req = 1'b0;
                end
            endcase
        end

        // Fill to full with in_valid held, 17th waits for one pop
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_char = 8'h60 + 8'(i);
            @(negedge clk);
            check($sformatf("fill_rdy%0d", i), {7'b0, in_ready}, 8'h01);
            step();
        end
        in_char = 8'h70;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("full_rdy", {7'b0, in_ready}, 8'h00);
            step();
        end
        bus_req = 1'b1; bus_write = 1'b0; bus_addr = 3'd0;
        @(negedge clk);
        check("full_pop", bus_rdata, 8'h60);
        check("full_pop_rdy", {7'b0, in_ready}, 8'h00);
        step();
        bus_req = 1'b0;
        @(negedge clk);
        check("after_pop_rdy", {7'b0, in_ready}, 8'h01);
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 16; i++) rd_chk($sformatf("drain%0d", i), 3'd0, 8'h60 + 8'(i));
        rd_chk("drain16", 3'd0, 8'h70);
        rd_chk("drain_lsr", 3'd5, 8'h60);

        // Reset mid-burst discards data and registers
        push(8'h11); push(8'h12);
        wr(3'd1, 8'h01); wr(3'd7, 8'h5A);
        @(negedge clk);
        check("pre_rst_irq", {7'b0, irq}, 8'h01);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_irq", {7'b0, irq}, 8'h00);
        check("post_rst_rdy", {7'b0, in_ready}, 8'h01);
        step();
        rd_chk("post_rst_lsr", 3'd5, 8'h60);
        rd_chk("post_rst_scr", 3'd7, 8'h00);
        rd_chk("post_rst_iir", 3'd2, 8'hC1);
        rd_chk("post_rst_ier", 3'd1, 8'h00);
        rd_chk("post_rst_rbr", 3'd0, 8'h00);

        // Randomized traffic against a queue-based model
        mq.delete();
        m_ier = 1'b0; m_lcr = 8'h00; m_dll = 8'h00; m_dlm = 8'h00; m_scr = 8'h00;
        m_trig = 1;
        for (int c = 0; c < 1200; c++) begin
            logic [7:0] e_rd;
            logic       e_rdy, e_irq, popped, pushed;
            int         fill_phase;
            fill_phase = ((c / 150) % 2 == 0) ? 1 : 0;
            in_valid  = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            in_char   = 8'($urandom);
            bus_req   = fill_phase ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            bus_write = ($urandom_range(0, 3) == 0);
            bus_addr  = fill_phase ? 3'($urandom) : (($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom));
            bus_wdata = 8'($urandom);
            if (bus_write && bus_addr == 3'd3) bus_wdata[7] = ($urandom_range(0, 3) == 0);
            if (bus_write && bus_addr == 3'd2 && $urandom_range(0, 3) != 0) bus_wdata[1] = 1'b0;

            e_rdy = (mq.size() < Depth);
            e_irq = m_ier && (mq.size() >= m_trig);
            case (bus_addr)
                3'd0:    e_rd = m_lcr[7] ? m_dll : ((mq.size() > 0) ? mq[0] : 8'h00);
                3'd1:    e_rd = m_lcr[7] ? m_dlm : {7'b0, m_ier};
                3'd2:    e_rd = e_irq ? 8'hC4 : 8'hC1;
                3'd3:    e_rd = m_lcr;
                3'd5:    e_rd = (mq.size() > 0) ? 8'h61 : 8'h60;
                3'd7:    e_rd = m_scr;
                default: e_rd = 8'h00;
            endcase

            @(negedge clk);
            check($sformatf("rnd%0d_rdy", c), {7'b0, in_ready}, {7'b0, e_rdy});
            check($sformatf("rnd%0d_irq", c), {7'b0, irq}, {7'b0, e_irq});
            if (bus_req && !bus_write) check($sformatf("rnd%0d_rd%0d", c, bus_addr), bus_rdata, e_rd);
            step();

            popped = bus_req && !bus_write && bus_addr == 3'd0 && !m_lcr[7] && mq.size() > 0;
            pushed = in_valid && (mq.size() < Depth);
            if (popped) void'(mq.pop_front());
            if (pushed) mq.push_back(in_char);
            if (bus_req && bus_write) begin
                case (bus_addr)
                    3'd0: if (m_lcr[7]) m_dll = bus_wdata;
                    3'd1: if (m_lcr[7]) m_dlm = bus_wdata; else m_ier = bus_wdata[0];
                    3'd2: begin
                        m_trig = trig_tab[bus_wdata[7:6]];
                        if (m_trig > Depth) m_trig = Depth;
                        if (bus_wdata[1]) mq.delete();
                    end
                    3'd3: m_lcr = bus_wdata;
                    3'd7: m_scr = bus_wdata;
                    default: ;
                endcase
            end
        end
        in_valid = 1'b0; bus_req = 1'b0; bus_write = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
